// File: rtl/mdma_ram_fifo_ctrl.sv
// FIFO controller that keeps its entries in an external single-port-per-direction RAM
// and prefetches into a 2-entry staging buffer so the pop side sees no RAM latency.
module mdma_ram_fifo_ctrl #(
    parameter int DATA_BITS = 48,
    parameter int DEPTH     = 512,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [DATA_BITS-1:0] in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [DATA_BITS-1:0] out_dat,
    output logic                 out_dbe,
    output logic [ADDR_BITS-1:0] ram_wadr,
    output logic                 ram_wen,
    output logic [DATA_BITS-1:0] ram_wdat,
    output logic                 ram_ren,
    output logic [ADDR_BITS-1:0] ram_radr,
    input  logic [DATA_BITS-1:0] ram_rdat,
    input  logic                 ram_rsbe,
    input  logic                 ram_rdbe,
    output logic [ADDR_BITS+1:0] count,
    output logic [15:0]          sbe_cnt,
    output logic                 dbe_sticky,
    input  logic                 err_clr
);

    localparam int CNT_BITS = ADDR_BITS + 2;
    localparam logic [ADDR_BITS:0] RAM_FULL = (ADDR_BITS+1)'(DEPTH);

    logic [ADDR_BITS-1:0] wptr;
    logic [ADDR_BITS-1:0] rptr;
    logic [ADDR_BITS:0]   ram_cnt;
    logic                 rd_pend;
    logic [1:0]           stg_cnt;
    logic [DATA_BITS-1:0] stg_dat0;
    logic [DATA_BITS-1:0] stg_dat1;
    logic                 stg_dbe0;
    logic                 stg_dbe1;

    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 capture;
    logic [2:0]           occupancy;
    logic [2:0]           occ_limit;

    assign in_rdy   = rst_n & (ram_cnt != RAM_FULL) & ~flush;
    assign push     = in_vld & in_rdy;
    assign out_vld  = (stg_cnt != 2'd0);
    assign pop      = out_vld & out_rdy;
    assign capture  = rd_pend & ~flush;

    // A same-cycle pop frees a staging slot, which is what keeps a full-rate stream flowing.
    assign occupancy = {1'b0, stg_cnt} + {2'b00, rd_pend};
    assign occ_limit = pop ? 3'd3 : 3'd2;
    assign issue     = ~flush & (ram_cnt != '0) & (occupancy < occ_limit);

    assign ram_wen  = push;
    assign ram_wadr = wptr;
    assign ram_wdat = in_dat;
    assign ram_ren  = issue;
    assign ram_radr = rptr;

    assign out_dat  = stg_dat0;
    assign out_dbe  = stg_dbe0 & out_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            count   <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            count   <= '0;
        end else begin
            wptr    <= wptr + ADDR_BITS'(push);
            rptr    <= rptr + ADDR_BITS'(issue);
            ram_cnt <= ram_cnt + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(issue);
            rd_pend <= issue;
            count   <= count + CNT_BITS'(push) - CNT_BITS'(pop);
        end
    end

    // Slot 0 is always the oldest entry; a pop shifts slot 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_cnt  <= 2'd0;
            stg_dat0 <= '0;
            stg_dat1 <= '0;
            stg_dbe0 <= 1'b0;
            stg_dbe1 <= 1'b0;
        end else if (flush) begin
            stg_cnt  <= 2'd0;
            stg_dbe0 <= 1'b0;
            stg_dbe1 <= 1'b0;
        end else begin
            case ({pop, capture})
                2'b01: begin
                    if (stg_cnt == 2'd0) begin
                        stg_dat0 <= ram_rdat;
                        stg_dbe0 <= ram_rdbe;
                    end else begin
                        stg_dat1 <= ram_rdat;
                        stg_dbe1 <= ram_rdbe;
                    end
                    stg_cnt <= stg_cnt + 2'd1;
                end
                2'b10: begin
                    stg_dat0 <= stg_dat1;
                    stg_dbe0 <= stg_dbe1;
                    stg_cnt  <= stg_cnt - 2'd1;
                end
                2'b11: begin
                    if (stg_cnt == 2'd1) begin
                        stg_dat0 <= ram_rdat;
                        stg_dbe0 <= ram_rdbe;
                    end else begin
                        stg_dat0 <= stg_dat1;
                        stg_dbe0 <= stg_dbe1;
                        stg_dat1 <= ram_rdat;
                        stg_dbe1 <= ram_rdbe;
                    end
                end
                default: ;
            endcase
        end
    end

    // Error events observed on a capture take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt    <= '0;
            dbe_sticky <= 1'b0;
        end else begin
            if (capture && ram_rsbe) begin
                if (sbe_cnt != 16'hFFFF) begin
                    sbe_cnt <= sbe_cnt + 16'd1;
                end
            end else if (err_clr) begin
                sbe_cnt <= '0;
            end
            if (capture && ram_rdbe) begin
                dbe_sticky <= 1'b1;
            end else if (err_clr) begin
                dbe_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mdma_ram_fifo_ctrl.sv
// Directed bench for mdma_ram_fifo_ctrl with a 1-cycle-latency RAM model and an
// in-order scoreboard of accepted pushes.
module tb_mdma_ram_fifo_ctrl;

    localparam int DATA_BITS = 48;
    localparam int DEPTH     = 16;
    localparam int ADDR_BITS = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_vld = 1'b0;
    logic                 out_rdy = 1'b0;
    logic                 err_clr = 1'b0;
    logic [DATA_BITS-1:0] in_dat = '0;

    logic                 in_rdy;
    logic                 out_vld;
    logic [DATA_BITS-1:0] out_dat;
    logic                 out_dbe;
    logic [ADDR_BITS-1:0] ram_wadr;
    logic                 ram_wen;
    logic [DATA_BITS-1:0] ram_wdat;
    logic                 ram_ren;
    logic [ADDR_BITS-1:0] ram_radr;
    logic [DATA_BITS-1:0] ram_rdat;
    logic                 ram_rsbe;
    logic                 ram_rdbe;
    logic [ADDR_BITS+1:0] count;
    logic [15:0]          sbe_cnt;
    logic                 dbe_sticky;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 sbe_mask [DEPTH];
    logic                 dbe_mask [DEPTH];

    int checks = 0;
    int failures = 0;
    int cycle_no = 0;
    int pops = 0;
    int pushes = 0;
    int first_vld = -1;
    logic push_dbe = 1'b0;
    logic [DATA_BITS:0] exp_q [$];

    mdma_ram_fifo_ctrl #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_dbe(out_dbe),
        .ram_wadr(ram_wadr), .ram_wen(ram_wen), .ram_wdat(ram_wdat),
        .ram_ren(ram_ren), .ram_radr(ram_radr),
        .ram_rdat(ram_rdat), .ram_rsbe(ram_rsbe), .ram_rdbe(ram_rdbe),
        .count(count), .sbe_cnt(sbe_cnt), .dbe_sticky(dbe_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // RAM model: data and error flags for an address come back the cycle after the read.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_wadr] <= ram_wdat;
        if (ram_ren) begin
            ram_rdat <= mem[ram_radr];
            ram_rsbe <= sbe_mask[ram_radr];
            ram_rdbe <= dbe_mask[ram_radr];
        end else begin
            ram_rsbe <= 1'b0;
            ram_rdbe <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_BITS-1:0] d, input logic r,
                                 input logic f, input logic c);
        in_vld  = v;
        in_dat  = d;
        out_rdy = r;
        flush   = f;
        err_clr = c;
        #1;
    endtask

    task automatic tick();
        logic [DATA_BITS:0] e;
        #2;
        if (out_vld && first_vld < 0) first_vld = cycle_no;
        if (in_vld && in_rdy) begin
            exp_q.push_back({push_dbe, in_dat});
            pushes++;
        end
        if (out_vld && out_rdy) begin
            pops++;
            if (exp_q.size() == 0) begin
                checkOutput("pop_with_empty_scoreboard", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pop_dat", 64'(out_dat), 64'(e[DATA_BITS-1:0]));
                checkOutput("pop_dbe", 64'(out_dbe), 64'(e[DATA_BITS]));
            end
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        checkOutput({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        checkOutput({tag, "_count0"}, 64'(count), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle_no);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int tp;
        int base;
        for (int i = 0; i < DEPTH; i++) begin
            sbe_mask[i] = 1'b0;
            dbe_mask[i] = 1'b0;
        end

        // Reset values with a push attempt held on the input
        in_vld = 1'b1;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("rst_out_vld", 64'(out_vld), 64'd0);
        checkOutput("rst_ram_wen", 64'(ram_wen), 64'd0);
        checkOutput("rst_ram_ren", 64'(ram_ren), 64'd0);
        checkOutput("rst_out_dbe", 64'(out_dbe), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_sbe_cnt", 64'(sbe_cnt), 64'd0);
        checkOutput("rst_dbe_sticky", 64'(dbe_sticky), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_in_rdy", 64'(in_rdy), 64'd1);

        // Five back-to-back pushes, sink always ready
        base = cycle_no;
        first_vld = -1;
        pops = 0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, DATA_BITS'(i), 1'b1, 1'b0, 1'b0);
            if (i == 1) begin
                checkOutput("first_wen", 64'(ram_wen), 64'd1);
                checkOutput("first_wadr", 64'(ram_wadr), 64'd0);
                checkOutput("first_ren_idle", 64'(ram_ren), 64'd0);
            end
            if (i == 2) begin
                checkOutput("ren_after_push", 64'(ram_ren), 64'd1);
                checkOutput("ren_radr", 64'(ram_radr), 64'd0);
            end
            tick();
        end
        drain("seq5");
        checkOutput("seq5_latency", 64'(first_vld - base), 64'd3);
        checkOutput("seq5_pops", 64'(pops), 64'd5);

        // Fill with the sink stalled: RAM plus two staging slots
        base = pushes;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, DATA_BITS'(32'h100 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, DATA_BITS'(32'h1FF), 1'b0, 1'b0, 1'b0);
        checkOutput("full_accepted", 64'(pushes - base), 64'(DEPTH + 2));
        checkOutput("full_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("full_count", 64'(count), 64'(DEPTH + 2));
        checkOutput("full_out_vld", 64'(out_vld), 64'd1);
        drain("full");

        // Long stream through several pointer wraps with a random sink
        n = 0;
        for (int i = 0; i < 600 && n < 3 * DEPTH; i++) begin
            applyStimulus(1'b1, DATA_BITS'(32'hB000 + n), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (in_rdy) n++;
            tick();
        end
        checkOutput("stream_pushed", 64'(n), 64'(3 * DEPTH));
        drain("stream");

        // Full-rate streaming once primed
        tp = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, DATA_BITS'(32'hC000 + i), 1'b1, 1'b0, 1'b0);
            if (i >= 4 && out_vld) tp++;
            tick();
        end
        checkOutput("throughput", 64'(tp), 64'd36);
        drain("tput");

        // Flush while a read is in flight and ten entries are held
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, DATA_BITS'(32'hD00 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("pre_flush_count", 64'(count), 64'd10);
        applyStimulus(1'b1, DATA_BITS'(32'hDFF), 1'b1, 1'b0, 1'b0);
        checkOutput("pre_flush_ren", 64'(ram_ren), 64'd1);
        tick();
        applyStimulus(1'b1, DATA_BITS'(32'hEEE), 1'b0, 1'b1, 1'b0);
        checkOutput("flush_held_count", 64'(count), 64'd10);
        checkOutput("flush_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("flush_wen", 64'(ram_wen), 64'd0);
        checkOutput("flush_ren", 64'(ram_ren), 64'd0);
        tick();
        exp_q.delete();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_flush_count", 64'(count), 64'd0);
        checkOutput("post_flush_out_vld", 64'(out_vld), 64'd0);
        checkOutput("post_flush_in_rdy", 64'(in_rdy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checkOutput("no_stale_return", 64'(out_vld), 64'd0);
            tick();
        end

        // Error reporting: pointers restart at 0 after the flush
        sbe_mask[0] = 1'b1;
        sbe_mask[1] = 1'b1;
        sbe_mask[3] = 1'b1;
        dbe_mask[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_dbe = (i == 2);
            applyStimulus(1'b1, DATA_BITS'(48'hE0E0_0000_0000 + i), 1'b0, 1'b0, 1'b0);
            if (i == 0) checkOutput("post_flush_wadr", 64'(ram_wadr), 64'd0);
            tick();
        end
        push_dbe = 1'b0;
        drain("err");
        checkOutput("sbe_cnt_3", 64'(sbe_cnt), 64'd3);
        checkOutput("dbe_sticky_set", 64'(dbe_sticky), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("sbe_cnt_clr", 64'(sbe_cnt), 64'd0);
        checkOutput("dbe_sticky_clr", 64'(dbe_sticky), 64'd0);

        // Asynchronous reset in the middle of a stream, with errors accumulating
        for (int i = 0; i < DEPTH; i++) begin
            sbe_mask[i] = 1'b1;
            dbe_mask[i] = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, DATA_BITS'(32'hF000 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_rdy", 64'(in_rdy), 64'd0);
        checkOutput("midrst_out_vld", 64'(out_vld), 64'd0);
        checkOutput("midrst_wen", 64'(ram_wen), 64'd0);
        checkOutput("midrst_ren", 64'(ram_ren), 64'd0);
        checkOutput("midrst_out_dbe", 64'(out_dbe), 64'd0);
        checkOutput("midrst_count", 64'(count), 64'd0);
        checkOutput("midrst_sbe_cnt", 64'(sbe_cnt), 64'd0);
        checkOutput("midrst_dbe_sticky", 64'(dbe_sticky), 64'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            sbe_mask[i] = 1'b0;
            dbe_mask[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pops = 0;
        applyStimulus(1'b1, 48'h1234_5678_9ABC, 1'b1, 1'b0, 1'b0);
        checkOutput("post_midrst_wadr", 64'(ram_wadr), 64'd0);
        tick();
        drain("midrst");
        checkOutput("post_midrst_pops", 64'(pops), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
